// File: rtl/timer_event_source_if.sv
// -----------------------------------------------------------------------------
// timer_event_source_if
//
// Purpose: groups the control, configuration and external-input signals of
// one timer event-source channel together with the event output.
//
// Signals (directions seen from the event source, i.e. the slave modport):
//   ctrl_active_i  in   channel running; low forces idle
//   ctrl_update_i  in   one-cycle strobe: load shadow config and re-arm
//   ctrl_rst_i     in   one-cycle soft reset of the datapath state
//   cfg_sel_i      in   [SEL_W]  external input index (>= NUM_IN selects 0)
//   cfg_mode_i     in   [3]      event mode
//   cfg_filt_i     in   [FILT_W] glitch-filter length N
//   signal_i       in   [NUM_IN] asynchronous external inputs
//   event_o        out  registered single-cycle event to the prescaler
//
// Modports:
//   master - the controller / environment driving the channel
//   slave  - the timer_event_source itself
// -----------------------------------------------------------------------------
interface timer_event_source_if #(
    parameter int NUM_IN = 32,
    parameter int FILT_W = 4,
    parameter int SEL_W  = $clog2(NUM_IN)
);

    logic              ctrl_active_i;
    logic              ctrl_update_i;
    logic              ctrl_rst_i;
    logic [SEL_W-1:0]  cfg_sel_i;
    logic [2:0]        cfg_mode_i;
    logic [FILT_W-1:0] cfg_filt_i;
    logic [NUM_IN-1:0] signal_i;
    logic              event_o;

    modport master (
        output ctrl_active_i,
        output ctrl_update_i,
        output ctrl_rst_i,
        output cfg_sel_i,
        output cfg_mode_i,
        output cfg_filt_i,
        output signal_i,
        input  event_o
    );

    modport slave (
        input  ctrl_active_i,
        input  ctrl_update_i,
        input  ctrl_rst_i,
        input  cfg_sel_i,
        input  cfg_mode_i,
        input  cfg_filt_i,
        input  signal_i,
        output event_o
    );

endinterface

// File: rtl/timer_event_source.sv
// -----------------------------------------------------------------------------
// timer_event_source
//
// Purpose: event-generation front end for one timer channel. Selects one of
// NUM_IN asynchronous inputs, synchronizes it through two flops, rejects
// glitches with a programmable digital filter and turns the filtered level
// into the single-cycle event stream consumed by the prescaler event input.
//
// Ports:
//   clk_i   in   timer clock
//   rstn_i  in   asynchronous, active-low reset
//   bus     slave modport of timer_event_source_if (control, configuration,
//           external inputs and the registered event_o)
//
// Behaviour summary:
//   - cfg_* is captured into shadow registers only on ctrl_update_i.
//   - Filter length N: a level change is accepted after N+1 consecutive
//     disagreeing samples; any agreeing sample restarts the count.
//   - After reset, soft reset, update or reactivation the channel spends
//     three active cycles re-arming, during which event_o is held low and the
//     filtered level simply tracks the synchronizer.
// -----------------------------------------------------------------------------
module timer_event_source #(
    parameter int NUM_IN = 32,
    parameter int FILT_W = 4,
    parameter int SEL_W  = $clog2(NUM_IN)
) (
    input logic                clk_i,
    input logic                rstn_i,
    timer_event_source_if.slave bus
);

    typedef enum logic [2:0] {
        MODE_LEVEL_HI = 3'd0,
        MODE_LEVEL_LO = 3'd1,
        MODE_RISE     = 3'd2,
        MODE_FALL     = 3'd3,
        MODE_BOTH     = 3'd4,
        MODE_ALWAYS   = 3'd5,
        MODE_NONE_6   = 3'd6,
        MODE_NONE_7   = 3'd7
    } mode_e;

    // Selector range rounded up to a power of two; indices past NUM_IN land
    // on constant-zero padding bits.
    localparam int PAD_W = 1 << SEL_W;

    // Shadow configuration
    logic [SEL_W-1:0]  r_sel;
    mode_e             r_mode;
    logic [FILT_W-1:0] r_filt;

    // Datapath state
    logic              s1;
    logic              s2;
    logic              stable;
    logic              prev;
    logic [FILT_W-1:0] cnt;
    logic [1:0]        arm;
    logic              event_q;

    logic [PAD_W-1:0]  sig_padded;
    logic              sel_bit;
    logic              event_next;
    logic              arming;

    // -------------------------------------------------------------------------
    // Shadow configuration: loaded only by the update strobe, independent of
    // whether the channel is active.
    // -------------------------------------------------------------------------
    // NOTE: sequential state is always written with non-blocking assignments
    // so every flop samples the pre-edge value of every other flop.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            r_sel  <= '0;
            r_mode <= MODE_LEVEL_HI;
            r_filt <= '0;
        end else if (bus.ctrl_update_i) begin
            r_sel  <= bus.cfg_sel_i;
            r_mode <= mode_e'(bus.cfg_mode_i);
            r_filt <= bus.cfg_filt_i;
        end
    end

    // -------------------------------------------------------------------------
    // Input select. The selector is registered, so the mux output only changes
    // right after an update, which the arming window then hides.
    // -------------------------------------------------------------------------
    // NOTE: every always_comb output gets a default first, so no path through
    // the block can leave it unassigned and infer a latch.
    always_comb begin
        sig_padded             = '0;
        sig_padded[NUM_IN-1:0] = bus.signal_i;
        sel_bit                = sig_padded[r_sel];
    end

    // Two-flop synchronizer; free-running, untouched by soft reset or idle.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            s1 <= 1'b0;
            s2 <= 1'b0;
        end else begin
            s1 <= sel_bit;
            s2 <= s1;
        end
    end

    // -------------------------------------------------------------------------
    // Event decode from the filtered level and its one-cycle-old copy.
    // -------------------------------------------------------------------------
    always_comb begin
        event_next = 1'b0;
        case (r_mode)
            MODE_LEVEL_HI: event_next = stable;
            MODE_LEVEL_LO: event_next = !stable;
            MODE_RISE:     event_next = stable & !prev;
            MODE_FALL:     event_next = !stable & prev;
            MODE_BOTH:     event_next = stable ^ prev;
            MODE_ALWAYS:   event_next = 1'b1;
            default:       event_next = 1'b0;
        endcase
    end

    // Any restart condition or a still-running arm count keeps the channel
    // in its quiet re-arming state.
    assign arming = bus.ctrl_update_i || !bus.ctrl_active_i || (arm != 2'd0);

    // -------------------------------------------------------------------------
    // Filter, arming and event register.
    // Priority: async reset > soft reset > update > inactive > normal.
    // -------------------------------------------------------------------------
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            stable  <= 1'b0;
            prev    <= 1'b0;
            cnt     <= '0;
            arm     <= 2'd3;
            event_q <= 1'b0;
        end else if (bus.ctrl_rst_i) begin
            stable  <= 1'b0;
            prev    <= 1'b0;
            cnt     <= '0;
            arm     <= 2'd3;
            event_q <= 1'b0;
        end else if (arming) begin
            // Restart conditions reload the full window; otherwise count down
            // one active cycle.
            if (bus.ctrl_update_i || !bus.ctrl_active_i) begin
                arm <= 2'd3;
            end else begin
                arm <= arm - 2'd1;
            end
            // Both stable and prev follow the synchronizer here so a level
            // that is already present when arming ends (including one from a
            // newly selected source still crossing the synchronizer) cannot
            // look like an edge.
            stable  <= s2;
            prev    <= s2;
            cnt     <= '0;
            event_q <= 1'b0;
        end else begin
            prev <= stable;
            if (s2 == stable) begin
                cnt <= '0;
            end else if (cnt == r_filt) begin
                stable <= s2;
                cnt    <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end
            event_q <= event_next;
        end
    end

    assign bus.event_o = event_q;

endmodule
